// File: rtl/hex_display_scan_pkg.sv
// Shared definitions for the hex display scanner: digit width, scan states
// and the one-hot digit-enable helper.
package hex_display_scan_pkg;

  // Width of one displayed digit (one hex nibble).
  localparam int DIGIT_W = 4;

  // Upper bound on digit positions the one-hot helper can encode.
  localparam int MAX_DIGITS = 32;

  // Scan states: dark, dead-time before a digit, digit lit.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } scan_state_e;

  // One-hot enable for digit position idx out of digits positions.
  // Positions outside the valid range yield an all-zero vector.
  function automatic logic [MAX_DIGITS-1:0] onehot(input int idx, input int digits);
    logic [MAX_DIGITS-1:0] vec;
    vec = {MAX_DIGITS{1'b0}};
    for (int k = 0; k < MAX_DIGITS; k++) begin
      if ((k < digits) && (k == idx)) begin
        vec[k] = 1'b1;
      end else begin
        vec[k] = vec[k];
      end
    end
    return vec;
  endfunction

endpackage

// File: rtl/hex_display_scan_scan_slot_timer.sv
// Per-digit slot timer: counts 0..TICK_DIV-1 while the scanner runs and flags
// the end of the dead-time window and the end of the whole slot.
module scan_slot_timer #(
  parameter int TICK_DIV     = 50000,
  parameter int BLANK_CYCLES = 256
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic blank_done,
  output logic slot_done
);

  localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_r;

  // Slot counter: held at zero while stopped, wraps to zero at slot end.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (!run) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (cnt_r == SLOT_LAST) begin
      cnt_r <= {CNT_W{1'b0}};
    end else begin
      cnt_r <= cnt_r + CNT_W'(1'b1);
    end
  end

  // Window-end flags are only meaningful while the slot is running.
  always_comb begin
    blank_done = run && (cnt_r == BLANK_LAST);
    slot_done  = run && (cnt_r == SLOT_LAST);
  end

endmodule

// File: rtl/hex_display_scan.sv
// Time-multiplexed hex display scanner. Walks the digit positions with a
// dead-time window before each digit, swaps in newly loaded values only at
// frame boundaries, and optionally blanks leading zeros. All outputs are
// registered from the next-state values so num/blank/digit_en move together.
module hex_display_scan
  import hex_display_scan_pkg::*;
#(
  parameter int DIGITS       = 4,
  parameter int TICK_DIV     = 50000,
  parameter int BLANK_CYCLES = 256,
  parameter int LZ_BLANK     = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [DIGIT_W*DIGITS-1:0] value_in,
  input  logic                      load,
  input  logic                      en,
  output logic [DIGIT_W-1:0]        num,
  output logic                      blank,
  output logic [DIGITS-1:0]         digit_en,
  output logic                      load_ack
);

  localparam int IDX_W = (DIGITS > 2) ? $clog2(DIGITS) : 1;
  localparam int VAL_W = DIGIT_W * DIGITS;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  scan_state_e         state_r;
  scan_state_e         state_next_s;
  logic [IDX_W-1:0]    idx_r;
  logic [IDX_W-1:0]    idx_next_s;
  logic [VAL_W-1:0]    active_r;
  logic [VAL_W-1:0]    active_next_s;
  logic [VAL_W-1:0]    shadow_r;
  logic [VAL_W-1:0]    shadow_next_s;
  logic                pending_r;
  logic                pending_next_s;
  logic                ack_next_s;
  logic                run_s;
  logic                blank_done_s;
  logic                slot_done_s;
  logic                wrap_s;
  logic [DIGIT_W-1:0]  num_next_s;
  logic                blank_next_s;
  logic [DIGITS-1:0]   digit_en_next_s;
  logic [DIGIT_W-1:0]  num_r;
  logic                blank_r;
  logic [DIGITS-1:0]   digit_en_r;
  logic                load_ack_r;

  // Nibble i of a display value.
  function automatic logic [DIGIT_W-1:0] nibble_of(input logic [VAL_W-1:0] v,
                                                   input logic [IDX_W-1:0] i);
    logic [DIGIT_W-1:0] nib;
    nib = {DIGIT_W{1'b0}};
    for (int k = 0; k < DIGITS; k++) begin
      if (IDX_W'(k) == i) begin
        nib = v[k*DIGIT_W +: DIGIT_W];
      end else begin
        nib = nib;
      end
    end
    return nib;
  endfunction

  // Leading-zero blank: digit i and every more significant digit are zero.
  // The least significant digit always shows, so a zero value reads "0".
  function automatic logic lz_blank_of(input logic [VAL_W-1:0] v,
                                       input logic [IDX_W-1:0] i);
    logic upper_zero;
    upper_zero = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if ((IDX_W'(k) >= i) && (v[k*DIGIT_W +: DIGIT_W] != {DIGIT_W{1'b0}})) begin
        upper_zero = 1'b0;
      end else begin
        upper_zero = upper_zero;
      end
    end
    return (LZ_BLANK != 0) && (i != {IDX_W{1'b0}}) && upper_zero;
  endfunction

  // The slot timer only runs while actively scanning; dropping en clears it.
  assign run_s = en && (state_r != IDLE);

  scan_slot_timer #(
    .TICK_DIV    (TICK_DIV),
    .BLANK_CYCLES(BLANK_CYCLES)
  ) u_slot_timer (
    .clk       (clk),
    .reset     (reset),
    .run       (run_s),
    .blank_done(blank_done_s),
    .slot_done (slot_done_s)
  );

  // Frame wrap: end of the last digit's slot, about to return to digit 0.
  assign wrap_s = en && (state_r == SHOW) && (idx_r == LAST_IDX) && slot_done_s;

  // Scan FSM state and digit index registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      idx_r   <= {IDX_W{1'b0}};
    end else begin
      state_r <= state_next_s;
      idx_r   <= idx_next_s;
    end
  end

  // Scan FSM next state: dead-time, then digit lit, then advance to next digit.
  always_comb begin
    state_next_s = state_r;
    idx_next_s   = idx_r;
    if (!en) begin
      state_next_s = IDLE;
      idx_next_s   = {IDX_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          state_next_s = BLANK;
          idx_next_s   = {IDX_W{1'b0}};
        end
        BLANK: begin
          if (blank_done_s) begin
            state_next_s = SHOW;
          end else begin
            state_next_s = BLANK;
          end
        end
        SHOW: begin
          if (slot_done_s) begin
            state_next_s = BLANK;
            if (idx_r == LAST_IDX) begin
              idx_next_s = {IDX_W{1'b0}};
            end else begin
              idx_next_s = idx_r + IDX_W'(1'b1);
            end
          end else begin
            state_next_s = SHOW;
          end
        end
        default: begin
          state_next_s = IDLE;
          idx_next_s   = {IDX_W{1'b0}};
        end
      endcase
    end
  end

  // Value path: loads land in the shadow and are promoted only at a frame
  // wrap so a frame never mixes old and new digits. While dark there is no
  // frame to tear, so a load goes straight to the active value. A load on
  // the wrap cycle itself skips the shadow and takes effect at that wrap.
  always_comb begin
    active_next_s  = active_r;
    shadow_next_s  = shadow_r;
    pending_next_s = pending_r;
    ack_next_s     = 1'b0;
    if (state_r == IDLE) begin
      if (load) begin
        active_next_s  = value_in;
        shadow_next_s  = value_in;
        pending_next_s = 1'b0;
        ack_next_s     = 1'b1;
      end else begin
        ack_next_s = 1'b0;
      end
    end else if (wrap_s) begin
      if (load) begin
        active_next_s  = value_in;
        shadow_next_s  = value_in;
        pending_next_s = 1'b0;
        ack_next_s     = 1'b1;
      end else if (pending_r) begin
        active_next_s  = shadow_r;
        pending_next_s = 1'b0;
        ack_next_s     = 1'b1;
      end else begin
        ack_next_s = 1'b0;
      end
    end else begin
      if (load) begin
        shadow_next_s  = value_in;
        pending_next_s = 1'b1;
      end else begin
        pending_next_s = pending_r;
      end
    end
  end

  // Active/shadow value and pending-load registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      active_r  <= {VAL_W{1'b0}};
      shadow_r  <= {VAL_W{1'b0}};
      pending_r <= 1'b0;
    end else begin
      active_r  <= active_next_s;
      shadow_r  <= shadow_next_s;
      pending_r <= pending_next_s;
    end
  end

  // Output decode from next-state values so the registered outputs line up
  // with the state they describe on the same edge.
  always_comb begin
    num_next_s      = {DIGIT_W{1'b0}};
    blank_next_s    = 1'b1;
    digit_en_next_s = {DIGITS{1'b0}};
    case (state_next_s)
      IDLE: begin
        num_next_s      = {DIGIT_W{1'b0}};
        blank_next_s    = 1'b1;
        digit_en_next_s = {DIGITS{1'b0}};
      end
      BLANK: begin
        num_next_s      = nibble_of(active_next_s, idx_next_s);
        blank_next_s    = 1'b1;
        digit_en_next_s = {DIGITS{1'b0}};
      end
      SHOW: begin
        num_next_s      = nibble_of(active_next_s, idx_next_s);
        blank_next_s    = lz_blank_of(active_next_s, idx_next_s);
        digit_en_next_s = DIGITS'(onehot(int'(idx_next_s), DIGITS));
      end
      default: begin
        num_next_s      = {DIGIT_W{1'b0}};
        blank_next_s    = 1'b1;
        digit_en_next_s = {DIGITS{1'b0}};
      end
    endcase
  end

  // Registered display outputs and load acknowledge pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      num_r      <= {DIGIT_W{1'b0}};
      blank_r    <= 1'b1;
      digit_en_r <= {DIGITS{1'b0}};
      load_ack_r <= 1'b0;
    end else begin
      num_r      <= num_next_s;
      blank_r    <= blank_next_s;
      digit_en_r <= digit_en_next_s;
      load_ack_r <= ack_next_s;
    end
  end

  assign num      = num_r;
  assign blank    = blank_r;
  assign digit_en = digit_en_r;
  assign load_ack = load_ack_r;

endmodule

// File: tb/tb_hex_display_scan.sv
// Testbench for hex_display_scan: directed scenarios followed by randomized
// traffic, all checked cycle by cycle against a frame-time reference model.
module tb_hex_display_scan;

  localparam int DIGITS       = 4;
  localparam int TICK_DIV     = 8;
  localparam int BLANK_CYCLES = 2;
  localparam int FRAME        = DIGITS * TICK_DIV;

  logic        clk = 1'b0;
  logic        reset;
  logic        load;
  logic        en;
  logic [15:0] value_in;
  logic [3:0]  num;
  logic        blank;
  logic [3:0]  digit_en;
  logic        load_ack;

  int checks = 0;
  int errors = 0;

  // Reference model: display value, staged value, and time since scan start.
  logic [15:0] m_active;
  logic [15:0] m_shadow;
  bit          m_pending;
  bit          m_scan;
  bit          m_ack;
  int          m_t;
  int          ack_seen;
  bit          check_num_idle;

  hex_display_scan #(
    .DIGITS      (DIGITS),
    .TICK_DIV    (TICK_DIV),
    .BLANK_CYCLES(BLANK_CYCLES),
    .LZ_BLANK    (1)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .value_in(value_in),
    .load    (load),
    .en      (en),
    .num     (num),
    .blank   (blank),
    .digit_en(digit_en),
    .load_ack(load_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (t=%0d)", tag, obs, exp, m_t);
    end
  endtask

  // Advance the model by one clock edge using the inputs present before it.
  task automatic model_edge();
    bit wrap;
    if (reset) begin
      m_active  = 16'h0;
      m_shadow  = 16'h0;
      m_pending = 1'b0;
      m_scan    = 1'b0;
      m_t       = 0;
      m_ack     = 1'b0;
    end else begin
      m_ack = 1'b0;
      wrap  = m_scan && en && ((m_t % FRAME) == FRAME - 1);
      if (!m_scan) begin
        if (load) begin
          m_active  = value_in;
          m_pending = 1'b0;
          m_ack     = 1'b1;
        end
      end else if (wrap) begin
        if (load) begin
          m_active  = value_in;
          m_pending = 1'b0;
          m_ack     = 1'b1;
        end else if (m_pending) begin
          m_active  = m_shadow;
          m_pending = 1'b0;
          m_ack     = 1'b1;
        end
      end else if (load) begin
        m_shadow  = value_in;
        m_pending = 1'b1;
      end
      if (!en) begin
        m_scan = 1'b0;
        m_t    = 0;
      end else if (!m_scan) begin
        m_scan = 1'b1;
        m_t    = 0;
      end else begin
        m_t = m_t + 1;
      end
    end
  endtask

  // Compare DUT outputs with what the model says the display shows now.
  task automatic compare();
    int digit;
    int phase;
    logic [3:0] exp_en;
    logic       exp_blank;
    logic [3:0] exp_num;
    digit     = (m_t / TICK_DIV) % DIGITS;
    phase     = m_t % TICK_DIV;
    exp_num   = 4'((m_active >> (4 * digit)) & 16'hF);
    exp_en    = 4'h0;
    exp_blank = 1'b1;
    if (m_scan && phase >= BLANK_CYCLES) begin
      exp_en    = 4'(1 << digit);
      exp_blank = (digit != 0) && ((m_active >> (4 * digit)) == 16'h0);
    end
    check("digit_en", 32'(digit_en), 32'(exp_en));
    check("blank", 32'(blank), 32'(exp_blank));
    check("load_ack", 32'(load_ack), 32'(m_ack));
    if (m_scan) begin
      check("num", 32'(num), 32'(exp_num));
    end else if (check_num_idle) begin
      check("num_idle", 32'(num), 32'h0);
    end
    if (load_ack) ack_seen++;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    compare();
  endtask

  // Run until the model sits at the given position within a frame.
  task automatic wait_pos(input int pos);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 3 * FRAME; i++) begin
      if (m_scan && ((m_t % FRAME) == pos)) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    check("wait_pos", 32'(found), 32'h1);
  endtask

  initial begin
    reset          = 1'b1;
    en             = 1'b0;
    load           = 1'b0;
    value_in       = 16'h0;
    ack_seen       = 0;
    check_num_idle = 1'b0;

    // Reset for three cycles, release with the display dark.
    repeat (3) tick();
    reset          = 1'b0;
    check_num_idle = 1'b1;
    tick();
    check_num_idle = 1'b0;

    // Direct load while dark, then scan two frames.
    value_in = 16'h12AF;
    load     = 1'b1;
    tick();
    load     = 1'b0;
    tick();
    en = 1'b1;
    repeat (2 * FRAME) tick();

    // Leading-zero blanking patterns.
    value_in = 16'h0050;
    load     = 1'b1;
    tick();
    load     = 1'b0;
    repeat (2 * FRAME) tick();
    value_in = 16'h0000;
    load     = 1'b1;
    tick();
    load     = 1'b0;
    repeat (2 * FRAME) tick();

    // Two loads mid-frame: old value until the wrap, then last one wins.
    value_in = 16'h5678;
    load     = 1'b1;
    tick();
    load     = 1'b0;
    repeat (2 * FRAME) tick();
    wait_pos(TICK_DIV + 3);
    ack_seen = 0;
    value_in = 16'h1234;
    load     = 1'b1;
    tick();
    load     = 1'b0;
    tick();
    value_in = 16'hBEEF;
    load     = 1'b1;
    tick();
    load     = 1'b0;
    repeat (FRAME) tick();
    check("single_ack_two_loads", 32'(ack_seen), 32'h1);

    // Load exactly on the frame-wrap cycle.
    wait_pos(FRAME - 1);
    ack_seen = 0;
    value_in = 16'h00C3;
    load     = 1'b1;
    tick();
    load     = 1'b0;
    repeat (FRAME + 4) tick();
    check("single_ack_wrap_load", 32'(ack_seen), 32'h1);

    // Reset while digit 2 is lit with a load pending.
    wait_pos(2 * TICK_DIV + 3);
    value_in = 16'hAAAA;
    load     = 1'b1;
    tick();
    load     = 1'b0;
    tick();
    reset          = 1'b1;
    check_num_idle = 1'b1;
    tick();
    check_num_idle = 1'b0;
    reset          = 1'b0;
    ack_seen       = 0;
    repeat (FRAME + 8) tick();
    check("no_ack_after_reset", 32'(ack_seen), 32'h0);

    // Randomized traffic: loads with sparse nibbles, en drops, rare resets.
    for (int i = 0; i < 600; i++) begin
      logic [15:0] v;
      v = 16'($urandom());
      for (int k = 0; k < 4; k++) begin
        if ($urandom_range(0, 1) == 0) v[4*k +: 4] = 4'h0;
      end
      value_in = v;
      load     = ($urandom_range(0, 9) == 0);
      en       = ($urandom_range(0, 59) != 0);
      reset    = ($urandom_range(0, 299) == 0);
      tick();
    end
    reset = 1'b0;
    load  = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
